// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets, CTRL bit
// positions, FSM encoding and default ID width.
package intc_pkg;

    localparam int INTC_ID_W = 8;

    // Register select values for Addr[4:2].
    localparam logic [2:0] REG_RAW      = 3'd0;
    localparam logic [2:0] REG_PENDING  = 3'd1;
    localparam logic [2:0] REG_ENABLE   = 3'd2;
    localparam logic [2:0] REG_MODE     = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_CLAIM    = 3'd5;
    localparam logic [2:0] REG_COMPLETE = 3'd6;

    localparam int CTRL_RR     = 0;
    localparam int CTRL_GIE    = 1;
    localparam int CTRL_ERR    = 8;
    localparam int CTRL_ACTIVE = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } intc_state_t;

endpackage

// File: rtl/intc_rr_arbiter.sv
// Combinational winner selection: fixed lowest-index priority, or round robin
// starting just after last_grant.
module intc_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic             rr,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int start;
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // Fixed priority is round robin anchored at the top index, so index 0 goes first.
        start  = rr ? int'(last_grant) : N_SRC - 1;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (start + k) % N_SRC;
            if (!valid && eligible[IDX_W'(idx)]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: edge/level capture, enable masking,
// fixed or round-robin arbitration and a claim/complete handshake to the CPU.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no source in service; IRQ may assert, CLAIM grants winner
//   ST_ACTIVE | source ID in service; masked from arbitration until COMPLETE
module intr_controller
    import intc_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = INTC_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             CS_N,
    input  logic             RD_N,
    input  logic             WR_N,
    input  logic [11:0]      Addr,
    input  logic [31:0]      DataIn,
    output logic [31:0]      DataOut,
    input  logic [N_SRC-1:0] IRQ_SRC,
    output logic             IRQ
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] pend_edge;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] mode;
    logic             rr;
    logic             gie;
    logic             err;
    intc_state_t      state, state_next;
    logic [ID_W-1:0]  id, id_next;
    logic [IDX_W-1:0] last_grant, last_grant_next;

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] svc_mask;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] claim_clr;
    logic [N_SRC-1:0] w1c_mask;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             claim_fire;
    logic             err_set;
    logic [31:0]      rd_data;

    logic       wr;
    logic [2:0] reg_sel;
    logic       unused_bits;

    assign wr          = ~CS_N & ~WR_N;
    assign reg_sel     = Addr[4:2];
    assign unused_bits = ^{Addr[11:5], Addr[1:0], DataIn};

    // Level sources report the last sample directly and cannot be cleared.
    assign pending  = (mode & pend_edge) | (~mode & src_prev);
    assign eligible = pending & enable & ~svc_mask;
    assign w1c_mask = (wr && reg_sel == REG_PENDING) ? DataIn[N_SRC-1:0] : '0;

    always_comb begin
        svc_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            svc_mask[i] = (state == ST_ACTIVE) && (id == ID_W'(i + 1));
        end
    end

    intc_rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible   (eligible),
        .rr         (rr),
        .last_grant (last_grant),
        .winner     (win_idx),
        .valid      (win_valid)
    );

    always_comb begin
        state_next      = state;
        id_next         = id;
        last_grant_next = last_grant;
        claim_fire      = 1'b0;
        err_set         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr && reg_sel == REG_CLAIM) begin
                    if (win_valid) begin
                        claim_fire      = 1'b1;
                        id_next         = ID_W'(win_idx) + ID_W'(1);
                        last_grant_next = win_idx;
                        state_next      = ST_ACTIVE;
                    end else begin
                        id_next = '0;
                    end
                end
                if (wr && reg_sel == REG_COMPLETE) begin
                    err_set = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (wr && reg_sel == REG_COMPLETE) begin
                    if (DataIn[ID_W-1:0] == id) begin
                        state_next = ST_IDLE;
                        id_next    = '0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign claim_clr = claim_fire ? (N_SRC'(1) << win_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            src_prev   <= '0;
            pend_edge  <= '0;
            enable     <= '0;
            mode       <= '0;
            rr         <= 1'b0;
            gie        <= 1'b0;
            err        <= 1'b0;
            state      <= ST_IDLE;
            id         <= '0;
            last_grant <= IDX_W'(N_SRC - 1);
            IRQ        <= 1'b0;
        end else begin
            src_prev  <= IRQ_SRC;
            // A new rise wins over a same-cycle W1C or claim clear.
            pend_edge <= (pend_edge & ~(w1c_mask | claim_clr)) | (IRQ_SRC & ~src_prev & mode);
            if (wr && reg_sel == REG_ENABLE) enable <= DataIn[N_SRC-1:0];
            if (wr && reg_sel == REG_MODE)   mode   <= DataIn[N_SRC-1:0];
            if (wr && reg_sel == REG_CTRL) begin
                rr  <= DataIn[CTRL_RR];
                gie <= DataIn[CTRL_GIE];
            end
            err        <= err_set | (err & ~(wr && reg_sel == REG_CTRL && DataIn[CTRL_ERR]));
            state      <= state_next;
            id         <= id_next;
            last_grant <= last_grant_next;
            // Suppress on the claim edge so IRQ falls right after the CPU claims.
            IRQ        <= gie && (state == ST_IDLE) && !claim_fire && (|eligible);
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_RAW:     rd_data = 32'(src_prev);
            REG_PENDING: rd_data = 32'(pending);
            REG_ENABLE:  rd_data = 32'(enable);
            REG_MODE:    rd_data = 32'(mode);
            REG_CTRL: begin
                rd_data[CTRL_RR]     = rr;
                rd_data[CTRL_GIE]    = gie;
                rd_data[CTRL_ERR]    = err;
                rd_data[CTRL_ACTIVE] = (state == ST_ACTIVE);
            end
            REG_CLAIM: begin
                rd_data              = 32'(id);
                rd_data[CTRL_ACTIVE] = (state == ST_ACTIVE);
            end
            default: rd_data = '0;
        endcase
    end

    assign DataOut = (~CS_N & ~RD_N) ? rd_data : 32'h0;

endmodule

// File: tb/tb_intr_controller.sv
// Directed and randomized checks of intr_controller against a small
// behavioural model of the arbitration and pending rules.
module tb_intr_controller;

    localparam int N = 4;

    localparam logic [11:0] A_RAW      = 12'h000;
    localparam logic [11:0] A_PENDING  = 12'h004;
    localparam logic [11:0] A_ENABLE   = 12'h008;
    localparam logic [11:0] A_MODE     = 12'h00C;
    localparam logic [11:0] A_CTRL     = 12'h010;
    localparam logic [11:0] A_CLAIM    = 12'h014;
    localparam logic [11:0] A_COMPLETE = 12'h018;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         CS_N = 1'b1;
    logic         RD_N = 1'b0;
    logic         WR_N = 1'b1;
    logic [11:0]  Addr = '0;
    logic [31:0]  DataIn = '0;
    logic [31:0]  DataOut;
    logic [N-1:0] IRQ_SRC = '0;
    logic         IRQ;

    int n_err = 0;
    int n_checks = 0;

    intr_controller #(.N_SRC(N), .ID_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS_N    (CS_N),
        .RD_N    (RD_N),
        .WR_N    (WR_N),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .IRQ_SRC (IRQ_SRC),
        .IRQ     (IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        CS_N = 1'b0; WR_N = 1'b0; RD_N = 1'b1; Addr = a; DataIn = d;
        tick();
        CS_N = 1'b1; WR_N = 1'b1; RD_N = 1'b0; DataIn = '0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        CS_N = 1'b0; WR_N = 1'b1; RD_N = 1'b0; Addr = a;
        #1;
        d = DataOut;
        CS_N = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    // Reference pick: walk the sources in service order from the starting point.
    function automatic int model_pick(input logic [N-1:0] elig, input bit rrm, input int last);
        int start;
        start = rrm ? last : N - 1;
        for (int k = 1; k <= N; k++) begin
            if (elig[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    initial begin
        logic [31:0]  v;
        logic [N-1:0] src, en, clr, pulses, mpend;
        bit           rrv;
        int           mlast, w;

        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_irq", {31'b0, IRQ}, 32'h0);
        check_reg("reset_pending", A_PENDING, 32'h0);
        check_reg("reset_enable", A_ENABLE, 32'h0);
        check_reg("reset_ctrl", A_CTRL, 32'h0);
        check_reg("reset_claim", A_CLAIM, 32'h0);

        // 1. single edge source
        wr(A_MODE, 32'hF);
        wr(A_ENABLE, 32'h1);
        wr(A_CTRL, 32'h2);
        IRQ_SRC = 4'b0001;
        tick();
        IRQ_SRC = 4'b0000;
        check_reg("edge_pending_t1", A_PENDING, 32'h1);
        check("edge_irq_t1", {31'b0, IRQ}, 32'h0);
        tick();
        check("edge_irq_t2", {31'b0, IRQ}, 32'h1);
        wr(A_CLAIM, 32'h0);
        check("edge_irq_after_claim", {31'b0, IRQ}, 32'h0);
        check_reg("edge_claim_id", A_CLAIM, 32'h0001_0001);
        check_reg("edge_pending_cleared", A_PENDING, 32'h0);
        wr(A_COMPLETE, 32'h1);
        tick();
        check("edge_irq_after_complete", {31'b0, IRQ}, 32'h0);
        check_reg("edge_claim_idle", A_CLAIM, 32'h0);

        // 2. fixed priority
        wr(A_ENABLE, 32'hF);
        IRQ_SRC = 4'b1010;
        tick();
        IRQ_SRC = 4'b0000;
        wr(A_CLAIM, 32'h0);
        check_reg("fixed_first", A_CLAIM, 32'h0001_0002);
        wr(A_COMPLETE, 32'h2);
        wr(A_CLAIM, 32'h0);
        check_reg("fixed_second", A_CLAIM, 32'h0001_0004);
        wr(A_COMPLETE, 32'h4);
        check_reg("fixed_pending_empty", A_PENDING, 32'h0);

        // 3. round robin over four held level sources
        wr(A_MODE, 32'h0);
        IRQ_SRC = 4'hF;
        wr(A_CTRL, 32'h3);
        for (int r = 0; r < 5; r++) begin
            logic [31:0] exp_id;
            exp_id = 32'((r % 4) + 1);
            wr(A_CLAIM, 32'h0);
            check("rr_round", {24'b0, DataOut[7:0]} | 32'h0, 32'h0);
            check_reg("rr_claim", A_CLAIM, 32'h0001_0000 | exp_id);
            wr(A_COMPLETE, exp_id);
        end

        // 4. level source survives complete and W1C
        wr(A_CTRL, 32'h2);
        wr(A_ENABLE, 32'h4);
        IRQ_SRC = 4'b0100;
        tick(); tick();
        check("level_irq", {31'b0, IRQ}, 32'h1);
        wr(A_CLAIM, 32'h0);
        check_reg("level_claim", A_CLAIM, 32'h0001_0003);
        wr(A_COMPLETE, 32'h3);
        check("level_irq_complete_edge", {31'b0, IRQ}, 32'h0);
        tick();
        check("level_irq_reassert", {31'b0, IRQ}, 32'h1);
        wr(A_PENDING, 32'h4);
        check_reg("level_w1c_ignored", A_PENDING, 32'h4);

        // 5. error cases
        wr(A_ENABLE, 32'h1);
        IRQ_SRC = 4'b0001;
        tick(); tick();
        wr(A_CLAIM, 32'h0);
        check_reg("err_claim1", A_CLAIM, 32'h0001_0001);
        wr(A_COMPLETE, 32'h2);
        check_reg("err_mismatch", A_CTRL, 32'h0001_0102);
        wr(A_CLAIM, 32'h0);
        check_reg("err_claim_in_active", A_CLAIM, 32'h0001_0001);
        wr(A_CTRL, 32'h102);
        check_reg("err_w1c", A_CTRL, 32'h0001_0002);
        wr(A_COMPLETE, 32'h1);
        check_reg("err_complete_ok", A_CTRL, 32'h0000_0002);
        wr(A_COMPLETE, 32'h1);
        check_reg("err_complete_idle", A_CTRL, 32'h0000_0102);
        wr(A_CTRL, 32'h102);

        // 6. set wins over same-cycle W1C; reset mid-service
        IRQ_SRC = 4'b0000;
        tick();
        wr(A_MODE, 32'hF);
        IRQ_SRC = 4'b0001;
        tick();
        IRQ_SRC = 4'b0000;
        tick();
        check_reg("same_pre", A_PENDING, 32'h1);
        IRQ_SRC = 4'b0001;
        wr(A_PENDING, 32'h1);
        check_reg("same_cycle_set_wins", A_PENDING, 32'h1);
        IRQ_SRC = 4'b0000;
        tick();
        wr(A_PENDING, 32'h1);
        check_reg("w1c_clears", A_PENDING, 32'h0);
        IRQ_SRC = 4'b0001;
        tick();
        IRQ_SRC = 4'b0000;
        wr(A_CLAIM, 32'h0);
        check_reg("pre_reset_active", A_CLAIM, 32'h0001_0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("reset_mid_irq", {31'b0, IRQ}, 32'h0);
        check_reg("reset_mid_claim", A_CLAIM, 32'h0);
        check_reg("reset_mid_ctrl", A_CTRL, 32'h0);
        check_reg("reset_mid_enable", A_ENABLE, 32'h0);

        // Randomized level-mode arbitration against the model
        mlast = N - 1;
        for (int it = 0; it < 24; it++) begin
            src = N'($urandom_range(0, 15));
            en  = N'($urandom_range(0, 15));
            rrv = 1'($urandom_range(0, 1));
            IRQ_SRC = src;
            wr(A_ENABLE, 32'(en));
            wr(A_CTRL, {30'b0, 1'b1, rrv});
            tick();
            check("rand_irq", {31'b0, IRQ}, {31'b0, |(src & en)});
            check_reg("rand_raw", A_RAW, 32'(src));
            w = model_pick(src & en, rrv, mlast);
            wr(A_CLAIM, 32'h0);
            if (w >= 0) begin
                check_reg("rand_claim", A_CLAIM, 32'h0001_0000 | 32'(w + 1));
                mlast = w;
                wr(A_COMPLETE, 32'(w + 1));
            end else begin
                check_reg("rand_claim_none", A_CLAIM, 32'h0);
            end
            check_reg("rand_no_err", A_CTRL, {30'b0, 1'b1, rrv});
        end

        // Randomized edge capture and W1C
        IRQ_SRC = '0;
        tick();
        wr(A_ENABLE, 32'h0);
        wr(A_MODE, 32'hF);
        mpend = '0;
        for (int it = 0; it < 16; it++) begin
            pulses = N'($urandom_range(0, 15));
            clr    = N'($urandom_range(0, 15));
            IRQ_SRC = pulses;
            tick();
            IRQ_SRC = '0;
            mpend = mpend | pulses;
            tick();
            wr(A_PENDING, 32'(clr));
            mpend = mpend & ~clr;
            check_reg("rand_edge_pending", A_PENDING, 32'(mpend));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
